multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Parametrised multi-cycle control unit; successor to the single-cycle matrix controller.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives the existing datapath strobes.
//  Adds a req/ack memory handshake with timeout, an illegal-instruction trap and a retired-instruction counter.
//  Sits between Datapathtop (oprtn/fcn source, strobe sink) and the instruction/data memory port.
// PARAMETERS
//  OP_W        6   opcode width (oprtn)
//  FN_W        6   function-field width (fcn)
//  ALUOP_W     4   ALUOperation width
//  MEM_TIMEOUT 15  wait cycles without MemAck before trap (1..2**TO_W-1)
//  TO_W        4   wait-counter width
//  CNT_W       16  retired-instruction counter width
// PORTS
//  Clk          in   1        clock, rising edge
//  Rst          in   1        synchronous reset, active-low
//  oprtn        in   OP_W     opcode from the IR
//  fcn          in   FN_W     function field from the IR
//  MemAck       in   1        memory completes the current request this cycle
//  MemReq       out  1        memory request (FETCH or lw/sw MEM)
//  MemWrt       out  1        request is a write (sw MEM only)
//  MemRd        out  1        request is a read
//  IRWrt        out  1        load the IR (FETCH && MemAck)
//  PCWrt        out  1        PC <= PC+4 (FETCH && MemAck)
//  Bnch         out  1        conditional PC load on Zero (beq EXEC)
//  RgWrt        out  1        register-file write (WB)
//  destReg      out  1        1 = rd (R-type), 0 = rt
//  ALUSc        out  1        1 = sign-extended immediate as ALU B operand
//  MemtReg      out  1        1 = memory data to the register file
//  ALUOperation out  ALUOP_W  ALU function
//  Trap         out  1        sticky error; the FSM is halted
//  TrapCause    out  2        01 illegal opcode, 10 illegal funct, 11 memory timeout
//  Retired      out  CNT_W    completed-instruction count, wraps
// BEHAVIOUR
//  Rst=0 at an edge: state <= FETCH; wait counter, Retired, Trap and TrapCause <= 0. This applies in every state, including mid-request.
//  All strobes decode from the state and the latched op/fn. While Rst=0 and in TRAP, every strobe is 0.
//  oprtn/fcn are latched on the DECODE cycle. Later changes are ignored until the next DECODE.
//  Decode: op 00 = R-type; 23 = lw; 2B = sw; 04 = beq; 08 = addi. Any other opcode -> TRAP, cause 01.
//  R-type funct to ALUOperation: 20 add -> 0010, 22 sub -> 0110, 24 and -> 0000, 25 or -> 0001, 2A slt -> 0111.
//  Any other funct -> TRAP, cause 10.
//  FETCH: MemReq=MemRd=1 until MemAck. In the MemAck cycle IRWrt=PCWrt=1 and next state is DECODE.
//  DECODE: one cycle, no strobes. Next state is EXEC, or TRAP.
//  EXEC: R-type uses ALUSc=0 and the funct mapping.
//  EXEC: lw/sw/addi use ALUSc=1, ALUOperation=0010.
//  EXEC: beq uses ALUSc=0, ALUOperation=0110, Bnch=1, then retires to FETCH.
//  MEM (lw/sw): MemReq=1; lw sets MemRd=1, sw sets MemWrt=1.
//  On MemAck, lw goes to WB and sw retires to FETCH.
//  WB: RgWrt=1. R-type adds destReg=1. lw adds MemtReg=1. addi uses destReg=0, MemtReg=0. Then retires to FETCH.
//  Minimum cycles with zero-wait ack: beq 3, R/addi/sw 4, lw 5.
//  Retire: Retired += 1 on the last-state exit edge. It wraps 2**CNT_W-1 -> 0.
//  Wait counter: clears on entry to FETCH/MEM and on MemAck; otherwise increments while MemReq=1.
//  When the counter reaches MEM_TIMEOUT with no ack that cycle -> TRAP, cause 11.
//  MemAck in the same cycle as the limit: ack wins, no trap.
//  MemAck outside FETCH/MEM is ignored.
//  TRAP: Trap=1, TrapCause holds, Retired holds. The only exit is reset.
// TESTING
//  1. Reset with Rst=0 for 2 cycles -> all strobes 0, Retired=0, Trap=0. First cycle after Rst=1: MemReq=1.
//  2. Zero-wait stream add(00/20), lw(23), sw(2B), beq(04) -> 4+5+4+3 cycles. Check strobes per state. Retired=4.
//  3. FETCH with MemAck held low 15 cycles -> Trap=1, TrapCause=11. With ack on the 15th cycle -> DECODE, no trap.
//  4. Opcode 3F -> TRAP cause 01 after DECODE. R-type funct 27 -> TRAP cause 10. Retired unchanged.
//  5. Rst=0 during lw MEM with MemReq=1 -> next cycle FETCH, MemWrt=MemRd=0 then fetch restarts, Retired=0.
//  6. CNT_W=2: five back-to-back beq -> Retired sequence 1,2,3,0,1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving the datapath strobes,
// with a req/ack memory handshake, wait timeout, illegal-instruction trap and retire counter.
module multicycle_ctrl #(
  parameter int OP_W        = 6,
  parameter int FN_W        = 6,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [OP_W-1:0]    oprtn,
  input  logic [FN_W-1:0]    fcn,
  input  logic               MemAck,
  output logic               MemReq,
  output logic               MemWrt,
  output logic               MemRd,
  output logic               IRWrt,
  output logic               PCWrt,
  output logic               Bnch,
  output logic               RgWrt,
  output logic               destReg,
  output logic               ALUSc,
  output logic               MemtReg,
  output logic [ALUOP_W-1:0] ALUOperation,
  output logic               Trap,
  output logic [1:0]         TrapCause,
  output logic [CNT_W-1:0]   Retired
);

  // state  | meaning
  // FETCH  | instruction read, waits for MemAck
  // DECODE | latch op/fn, classify
  // EXEC   | ALU operation (beq retires here)
  // MEM    | lw/sw data access, waits for MemAck
  // WB     | register-file write, retires
  // TRAP   | halted until reset
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [OP_W-1:0] OP_R    = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'('h08);

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [2:0]      state, state_n;
  logic [OP_W-1:0] op_q;
  logic [FN_W-1:0] fn_q;
  logic [TO_W-1:0] wait_cnt;
  logic [1:0]      cause_n;
  logic            retire;
  logic            r_q, lw_q, sw_q, beq_q;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

  function automatic logic fn_legal(input logic [FN_W-1:0] fn);
    case (fn)
      FN_W'('h20), FN_W'('h22), FN_W'('h24), FN_W'('h25), FN_W'('h2A): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] fn_alu(input logic [FN_W-1:0] fn);
    case (fn)
      FN_W'('h20): return ALUOP_W'(4'b0010);
      FN_W'('h22): return ALUOP_W'(4'b0110);
      FN_W'('h24): return ALUOP_W'(4'b0000);
      FN_W'('h25): return ALUOP_W'(4'b0001);
      FN_W'('h2A): return ALUOP_W'(4'b0111);
      default:     return '0;
    endcase
  endfunction

  assign r_q   = (op_q == OP_R);
  assign lw_q  = (op_q == OP_LW);
  assign sw_q  = (op_q == OP_SW);
  assign beq_q = (op_q == OP_BEQ);

  always_comb begin
    state_n = state;
    cause_n = 2'b00;
    retire  = 1'b0;
    case (state)
      S_FETCH: begin
        if (MemAck) state_n = S_DECODE;
        else if (wait_cnt == WAIT_LAST) begin
          state_n = S_TRAP;
          cause_n = 2'b11;
        end
      end
      S_DECODE: begin
        if (!op_legal(oprtn)) begin
          state_n = S_TRAP;
          cause_n = 2'b01;
        end else if ((oprtn == OP_R) && !fn_legal(fcn)) begin
          state_n = S_TRAP;
          cause_n = 2'b10;
        end else state_n = S_EXEC;
      end
      S_EXEC: begin
        if (beq_q) begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end else if (lw_q || sw_q) state_n = S_MEM;
        else state_n = S_WB;
      end
      S_MEM: begin
        if (MemAck) begin
          state_n = lw_q ? S_WB : S_FETCH;
          retire  = sw_q;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = S_TRAP;
          cause_n = 2'b11;
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is asserted, independent of the state register.
  always_comb begin
    MemReq       = 1'b0;
    MemWrt       = 1'b0;
    MemRd        = 1'b0;
    IRWrt        = 1'b0;
    PCWrt        = 1'b0;
    Bnch         = 1'b0;
    RgWrt        = 1'b0;
    destReg      = 1'b0;
    ALUSc        = 1'b0;
    MemtReg      = 1'b0;
    ALUOperation = '0;
    if (Rst) begin
      case (state)
        S_FETCH: begin
          MemReq = 1'b1;
          MemRd  = 1'b1;
          IRWrt  = MemAck;
          PCWrt  = MemAck;
        end
        S_EXEC: begin
          if (r_q) ALUOperation = fn_alu(fn_q);
          else if (beq_q) begin
            ALUOperation = ALUOP_W'(4'b0110);
            Bnch         = 1'b1;
          end else begin
            ALUOperation = ALUOP_W'(4'b0010);
            ALUSc        = 1'b1;
          end
        end
        S_MEM: begin
          MemReq = 1'b1;
          MemRd  = lw_q;
          MemWrt = sw_q;
        end
        S_WB: begin
          RgWrt   = 1'b1;
          destReg = r_q;
          MemtReg = lw_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      Retired   <= '0;
      Trap      <= 1'b0;
      TrapCause <= 2'b00;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        op_q <= oprtn;
        fn_q <= fcn;
      end
      if ((state_n != state) || (MemReq && MemAck)) wait_cnt <= '0;
      else if (MemReq) wait_cnt <= wait_cnt + TO_W'(1);
      if (retire) Retired <= Retired + CNT_W'(1);
      if ((state != S_TRAP) && (state_n == S_TRAP)) begin
        Trap      <= 1'b1;
        TrapCause <= cause_n;
      end
    end
  end

endmodule
